// File: rtl/cdb_arbiter_if.sv
// FU-to-arbiter result bus plus the registered CDB broadcast back to the core.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int XLEN  = `XLEN,
  parameter int TAG_W = `ROB_TAG_LEN
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                        flush;
  logic [N_REQ-1:0]            fu_valid;
  logic [N_REQ-1:0][TAG_W-1:0] fu_tag;
  logic [N_REQ-1:0][XLEN-1:0]  fu_value;
  logic [N_REQ-1:0]            fu_full;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [XLEN-1:0]             cdb_value;
  logic [SRC_W-1:0]            cdb_src;

  modport master (
    output flush, fu_valid, fu_tag, fu_value,
    input  fu_full, cdb_valid, cdb_tag, cdb_value, cdb_src
  );

  modport slave (
    input  flush, fu_valid, fu_tag, fu_value,
    output fu_full, cdb_valid, cdb_tag, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-FU result FIFOs; 2-cycle push-to-broadcast latency.
// Backpressure: fu_full[i] from registered count only, so a same-cycle pop never frees a slot.
module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BUF_DEPTH = 2,
  parameter int XLEN      = `XLEN,
  parameter int TAG_W     = `ROB_TAG_LEN
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [TAG_W-1:0] r_mem_tag [N_REQ][BUF_DEPTH];
  logic [XLEN-1:0]  r_mem_val [N_REQ][BUF_DEPTH];
  logic [PTR_W-1:0] r_head    [N_REQ];
  logic [PTR_W-1:0] r_tail    [N_REQ];
  logic [CNT_W-1:0] r_count   [N_REQ];
  logic [SRC_W-1:0] r_rr_ptr;
  logic             r_cdb_valid;
  logic [TAG_W-1:0] r_cdb_tag;
  logic [XLEN-1:0]  r_cdb_value;
  logic [SRC_W-1:0] r_cdb_src;

  logic [N_REQ-1:0] w_full;
  logic [N_REQ-1:0] w_nonempty;
  logic [N_REQ-1:0] w_push;
  logic [N_REQ-1:0] w_pop;
  logic             w_grant_vld;
  logic [SRC_W-1:0] w_grant_idx;
  logic [SRC_W-1:0] w_cand;
  logic [SRC_W-1:0] w_rr_next;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_full[i]     = (r_count[i] == CNT_W'(BUF_DEPTH));
      w_nonempty[i] = (r_count[i] != '0);
      w_push[i]     = bus.fu_valid[i] & ~w_full[i] & ~bus.flush;
    end
  end

  // First non-empty buffer at or after rr_ptr, wrapping; new pushes are not visible yet.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = SRC_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_grant_vld && w_nonempty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_pop[i] = w_grant_vld && (w_grant_idx == SRC_W'(i));
    end
    w_rr_next = (w_grant_idx == SRC_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_push[i]) r_tail[i] <= r_tail[i] + 1'b1;
        if (w_pop[i])  r_head[i] <= r_head[i] + 1'b1;
        if (w_push[i] && !w_pop[i])
          r_count[i] <= r_count[i] + 1'b1;
        else if (!w_push[i] && w_pop[i])
          r_count[i] <= r_count[i] - 1'b1;
      end
      if (w_grant_vld) r_rr_ptr <= w_rr_next;
      r_cdb_valid <= w_grant_vld;
      r_cdb_tag   <= w_grant_vld ? r_mem_tag[w_grant_idx][r_head[w_grant_idx]] : '0;
      r_cdb_value <= w_grant_vld ? r_mem_val[w_grant_idx][r_head[w_grant_idx]] : '0;
      r_cdb_src   <= w_grant_vld ? w_grant_idx : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_push[i]) begin
        r_mem_tag[i][r_tail[i]] <= bus.fu_tag[i];
        r_mem_val[i][r_tail[i]] <= bus.fu_value[i];
      end
    end
  end

  // Overflowing pushes are dropped; flag the FU protocol violation without halting the run.
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        assert (!(bus.fu_valid[i] && w_full[i]))
          else $warning("cdb_arbiter: FU%0d pushed while its buffer is full, result dropped", i);
      end
    end
  end

  assign bus.fu_full   = w_full;
  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_value = r_cdb_value;
  assign bus.cdb_src   = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench for cdb_arbiter: per-FU expected queues plus cycle-exact grant checks.
module tb_cdb_arbiter;
  localparam int N_REQ     = 4;
  localparam int BUF_DEPTH = 2;
  localparam int XLEN      = 32;
  localparam int TAG_W     = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N_REQ), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.N_REQ(N_REQ), .BUF_DEPTH(BUF_DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [TAG_W-1:0] sb_tag [N_REQ][$];
  logic [XLEN-1:0]  sb_val [N_REQ][$];
  int               obs_src [$];
  int               obs_tag [$];
  bit               mon_en = 1'b0;
  int               m_src;
  logic [TAG_W-1:0] m_tag;
  logic [XLEN-1:0]  m_val;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fu_valid = '0;
  endtask

  task automatic push(input int i, input int tag, input logic [XLEN-1:0] val);
    bus.fu_valid[i] = 1'b1;
    bus.fu_tag[i]   = TAG_W'(tag);
    bus.fu_value[i] = val;
    sb_tag[i].push_back(TAG_W'(tag));
    sb_val[i].push_back(val);
  endtask

  task automatic sb_clear();
    for (int i = 0; i < N_REQ; i++) begin
      sb_tag[i].delete();
      sb_val[i].delete();
    end
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    sb_clear();
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int pending;
    pending = 0;
    for (int c = 0; c < 40; c++) begin
      pending = 0;
      for (int i = 0; i < N_REQ; i++) pending += sb_tag[i].size();
      if (pending == 0 && !bus.cdb_valid) break;
      tick();
    end
    check(name, pending, 0);
  endtask

  // Every broadcast must match the oldest outstanding result of its source FU.
  always @(negedge clk) begin
    if (mon_en && bus.cdb_valid) begin
      m_src = int'(bus.cdb_src);
      obs_src.push_back(m_src);
      obs_tag.push_back(int'(bus.cdb_tag));
      check("sb_pending", sb_tag[m_src].size() != 0, 1);
      if (sb_tag[m_src].size() != 0) begin
        m_tag = sb_tag[m_src].pop_front();
        m_val = sb_val[m_src].pop_front();
        check("sb_tag", bus.cdb_tag, m_tag);
        check("sb_value", bus.cdb_value, m_val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f3 [$];
    int n9;
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.fu_valid = '0;
    bus.fu_tag   = '0;
    bus.fu_value = '0;
    repeat (3) tick();
    check("rst_cdb_valid", bus.cdb_valid, 0);
    check("rst_cdb_tag", bus.cdb_tag, 0);
    check("rst_cdb_value", bus.cdb_value, 0);
    check("rst_cdb_src", bus.cdb_src, 0);
    check("rst_fu_full", bus.fu_full, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single uncontended result: two-cycle latency, one-cycle pulse.
    push(0, 5, 32'hDEADBEEF);
    tick(); idle();
    check("t1_no_bypass", bus.cdb_valid, 0);
    tick();
    check("t1_valid", bus.cdb_valid, 1);
    check("t1_tag", bus.cdb_tag, 5);
    check("t1_value", bus.cdb_value, 32'hDEADBEEF);
    check("t1_src", bus.cdb_src, 0);
    tick();
    check("t1_valid_low", bus.cdb_valid, 0);
    check("t1_tag_zero", bus.cdb_tag, 0);

    // All four FUs at once from rr_ptr = 0.
    do_flush();
    for (int i = 0; i < N_REQ; i++) push(i, i + 1, 32'(100 + i));
    tick(); idle();
    tick();
    for (int k = 0; k < N_REQ; k++) begin
      check("t2_valid", bus.cdb_valid, 1);
      check("t2_src", bus.cdb_src, k);
      check("t2_tag", bus.cdb_tag, k + 1);
      tick();
    end
    check("t2_idle", bus.cdb_valid, 0);

    // Move rr_ptr to 2, then FU1 and FU3 contend: FU3 wins first.
    push(1, 11, 32'h11);
    tick(); idle(); tick();
    check("t3_setup_src", bus.cdb_src, 1);
    push(1, 12, 32'h12);
    push(3, 13, 32'h13);
    tick(); idle(); tick();
    check("t3_first_src", bus.cdb_src, 3);
    tick();
    check("t3_second_src", bus.cdb_src, 1);
    tick();
    check("t3_idle", bus.cdb_valid, 0);
    push(1, 14, 32'h14);
    push(2, 15, 32'h15);
    tick(); idle(); tick();
    check("t3_rr_at_2", bus.cdb_src, 2);
    tick();
    check("t3_rr_then_1", bus.cdb_src, 1);
    drain("t3_drain");

    // FU3 fills while FU0..2 keep the bus busy; an overflow push is dropped.
    do_flush();
    obs_src.delete(); obs_tag.delete();
    for (int i = 0; i < 3; i++) push(i, 20 + i, 32'(200 + i));
    push(3, 7, 32'h777);
    tick();
    for (int i = 0; i < 3; i++) push(i, 23 + i, 32'(203 + i));
    push(3, 8, 32'h888);
    tick(); idle();
    check("t4_full_a", bus.fu_full, 4'b1110);
    bus.fu_valid[3] = 1'b1;
    bus.fu_tag[3]   = TAG_W'(9);
    bus.fu_value[3] = 32'h999;
    tick(); idle();
    check("t4_full_b", bus.fu_full, 4'b1100);
    tick();
    check("t4_full_pop_same_cycle", bus.fu_full, 4'b1000);
    tick();
    check("t4_full_c", bus.fu_full, 4'b0000);
    drain("t4_drain");
    f3.delete();
    n9 = 0;
    foreach (obs_src[j]) begin
      if (obs_src[j] == 3) f3.push_back(obs_tag[j]);
      if (obs_tag[j] == 9) n9++;
    end
    check("t4_fu3_count", f3.size(), 2);
    if (f3.size() == 2) begin
      check("t4_fu3_first", f3[0], 7);
      check("t4_fu3_second", f3[1], 8);
    end
    check("t4_no_tag9", n9, 0);

    // FU2 streams one result per cycle with no other traffic.
    for (int k = 0; k < 12; k++) begin
      idle();
      if (k < 10) push(2, 10 + k, 32'(1000 + k));
      check("t5_never_full", bus.fu_full, 0);
      if (k >= 2) begin
        check("t5_valid", bus.cdb_valid, 1);
        check("t5_src", bus.cdb_src, 2);
        check("t5_tag", bus.cdb_tag, 10 + k - 2);
      end
      tick();
    end
    idle();
    check("t5_end_idle", bus.cdb_valid, 0);

    // Flush with three results pending; the flush-cycle push is ignored.
    obs_src.delete(); obs_tag.delete();
    push(0, 30, 32'h30);
    push(1, 31, 32'h31);
    push(3, 33, 32'h33);
    tick(); idle();
    bus.flush       = 1'b1;
    bus.fu_valid[2] = 1'b1;
    bus.fu_tag[2]   = TAG_W'(40);
    bus.fu_value[2] = 32'h40;
    sb_clear();
    tick();
    bus.flush = 1'b0;
    idle();
    check("t6_valid_cleared", bus.cdb_valid, 0);
    check("t6_full_cleared", bus.fu_full, 0);
    repeat (4) tick();
    check("t6_no_stale", obs_src.size(), 0);
    push(1, 50, 32'h5050);
    tick(); idle(); tick();
    check("t6_fresh_valid", bus.cdb_valid, 1);
    check("t6_fresh_src", bus.cdb_src, 1);
    check("t6_fresh_tag", bus.cdb_tag, 50);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between the four functional units that the dispatcher feeds: ALU, MULT, BTU and LSU.
- Each FU pushes completed results into a small per-FU result buffer here.
- Each cycle the block grants at most one buffered result, round-robin, and drives it onto a registered CDB broadcast.
- That broadcast wakes up the RS entries, the ROB write-back and the map table ready tags (`rob_tag_from_cdb`).

Parameters:
- N_REQ, 4, number of requesters; index equals the FU enum value used for `RS_load`/`RS_is_full`.
- BUF_DEPTH, 2, entries per requester buffer; power of 2, ≥2.
- XLEN, `XLEN, result value width.
- TAG_W, `ROB_TAG_LEN, ROB tag width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash (mispredict/ROB flush); clears all pending results.
- fu_valid  in  N_REQ  FU i presents a completed result this cycle.
- fu_tag  in  N_REQ×TAG_W  destination ROB tag per FU.
- fu_value  in  N_REQ×XLEN  result value per FU.
- fu_full  out  N_REQ  buffer i is full; FU i must not assert fu_valid.
- cdb_valid  out  1  CDB broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_value  out  XLEN  broadcast value.
- cdb_src  out  log2(N_REQ)  index of the granted FU.

Behaviour:
- Reset: all buffers empty; rr_ptr = 0; fu_full = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_src = 0.
- Buffers:
  - One FIFO per requester: head/tail pointers wrap modulo BUF_DEPTH, plus a count (0..BUF_DEPTH).
  - fu_full[i] = (count_i == BUF_DEPTH), decoded from registered count only.
  - A pop in the same cycle does not lower fu_full.
- Push: fu_valid[i] & ~fu_full[i] & ~flush writes {tag, value} at the tail on the clock edge.
  - fu_valid[i] while fu_full[i] is a protocol error: the data is dropped and a simulation assertion fires.
- Eligibility: an entry becomes eligible the cycle after it is written; there is no same-cycle bypass.
- Arbitration (combinational over non-empty buffers):
  - Search from rr_ptr, ascending, modulo N_REQ; the first non-empty buffer wins.
  - Exactly zero or one grant per cycle.
  - A grant pops the head of the winning buffer.
- Round-robin pointer: after a grant to i, rr_ptr <= (i+1) mod N_REQ. With no grant, rr_ptr holds.
- CDB registers, loaded every edge:
  - Grant: cdb_valid = 1, cdb_tag/cdb_value = head entry, cdb_src = i.
  - No grant: cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0.
- Latency: fu_valid in cycle c → cdb_valid in cycle c+2 at minimum, when uncontended.
- Same-FU push and pop in one cycle: count unchanged, FIFO order preserved.
- Ordering: per-requester results leave in push order; ordering across requesters is not guaranteed.
- Fairness: a non-empty buffer is granted within N_REQ grant cycles.
- Flush:
  - On the edge it is sampled: all counts/pointers cleared, rr_ptr = 0, CDB registers cleared (cdb_valid = 0 the next cycle).
  - fu_valid in the flush cycle is ignored.
  - fu_full = 0 from the next cycle.
- Reset and flush asserted together: same result as reset.

Test Plan:
- Reset, then fu_valid[0] with tag 5 and value 0xDEADBEEF in cycle 1 → in cycle 3: cdb_valid = 1, tag = 5, value = 0xDEADBEEF, src = 0. Cycle 4: cdb_valid = 0. rr_ptr = 1.
- All four fu_valid in cycle 1 with tags 1..4 and rr_ptr = 0 → cycles 3, 4, 5, 6 carry src 0, 1, 2, 3 and tags 1, 2, 3, 4. Then cdb_valid = 0.
- rr_ptr = 2 with requests from FU1 and FU3 pending → FU3 granted first, then FU1. rr_ptr ends at 2.
- FU3 pushes tags 7 and 8 on consecutive cycles while FU0–2 keep the bus busy → fu_full[3] = 1 once count reaches 2. A bench push while full triggers the assertion. Tags 7, 8 later appear in order.
- FU2 pushes every cycle, tags 10..19, with no other traffic → cdb_valid continuous for 10 cycles, tags 10..19 in order, fu_full[2] never 1.
- Three entries buffered (FU0, FU1, FU3) and flush pulsed → next cycle cdb_valid = 0, fu_full = 0000, no stale tag ever broadcast. A fresh FU1 push afterwards appears 2 cycles later with src = 1.
